blast_sequencer: RTL and testbench
==================================

// Module: blast_sequencer
// PURPOSE
// - Timing/control producer for the blue-blast bitmap renderer: owns one bomb's lifecycle (arm, fuse, blast, cooldown).
// - Drives the renderer's blast / blast_num pair so the renderer latches a stable pattern index while blast is low.
// - Counts frames via startOfFrame.
// - Sits between bomb-placement logic (player/keypad) and the blast bitmap/collision logic.
// PARAMETERS
// - FUSE_FRAMES      120  frames from placement to detonation (>=2)
// - BLAST_FRAMES      30  frames blast stays asserted (>=1)
// - COOLDOWN_FRAMES    8  frames after blast before a new bomb is accepted (>=0)
// - NUM_PATTERNS       3  valid blast_num codes 0..NUM_PATTERNS-1 (0 cross, 1 vertical, 2 horizontal)
// PORTS
// - clk             in   1  system clock
// - reset           in   1  synchronous, active-high reset
// - startOfFrame    in   1  one-clk pulse per video frame
// - bomb_place      in   1  one-clk request to arm a bomb
// - pattern_sel     in   3  pattern index sampled with bomb_place
// - detonate_now    in   1  chain-reaction trigger (used only with CHAIN_DETONATE_EN)
// - blast           out  1  high for the whole BLAST state
// - blast_num       out  3  pattern index for the renderer; stable from ARMED entry to BLAST exit
// - bomb_armed      out  1  high in ARMED (bomb sprite visible)
// - busy            out  1  high in any state except IDLE
// - blast_done      out  1  one-clk pulse on BLAST->COOLDOWN
// BEHAVIOUR
// - Reset (sync, active-high): state=IDLE, frame counter=0, blast=0, blast_num=0, bomb_armed=0, busy=0, blast_done=0.
// - Registered FSM, all outputs registered; response latency is 1 clk after the qualifying input edge.
// - IDLE: bomb_place=1 -> ARMED. Latch blast_num <= pattern_sel; if pattern_sel>=NUM_PATTERNS, latch 0. Clear counter.
// - ARMED: counter++ on each startOfFrame. At FUSE_FRAMES-1 with startOfFrame -> BLAST, counter cleared.
// - BLAST: blast=1; counter++ per frame. At BLAST_FRAMES-1 with startOfFrame -> COOLDOWN, blast_done pulses 1 clk.
// - COOLDOWN: counter++ per frame. At COOLDOWN_FRAMES-1 with startOfFrame -> IDLE. If COOLDOWN_FRAMES=0, go straight to IDLE next clk.
// - Renderer handshake:
//   - blast_num must not change while blast=1 or in the clk blast rises.
//   - blast_num is written only on IDLE->ARMED, so it is stable >= FUSE_FRAMES frames before blast rises.
// - bomb_place outside IDLE is ignored (no queueing); pattern_sel is ignored outside IDLE.
// - Counter width = $clog2(max(FUSE,BLAST,COOLDOWN)_FRAMES)+1; no wrap can occur because the count resets on every state change.
// - startOfFrame and bomb_place in the same clk in IDLE: arm only. That frame is not counted toward the fuse.
// - Reset mid-BLAST: blast drops to 0 the next clk and blast_done is not pulsed.
// CONFIGURATION
// - `CHAIN_DETONATE_EN defined:
//   - detonate_now=1 in ARMED -> BLAST next clk regardless of counter (counter cleared); ignored in other states.
//   - detonate_now and the fuse expiry in the same clk: a single transition to BLAST.
// - Not defined: detonate_now is unconnected internally and the bomb always runs the full fuse.
// STRUCTURE
// - blast_pkg:
//   - typedef enum logic [1:0] {IDLE, ARMED, BLAST, COOLDOWN} blast_state_t
//   - localparams PAT_CROSS=0, PAT_VERT=1, PAT_HORZ=2; shared with the blast bitmap.
// - One sub-module, frame_tick_counter: clear, enable=startOfFrame, terminal-count compare, out hit.
//   - Instantiated once; the FSM muxes its terminal value by state.
// TESTING (bench uses FUSE=4, BLAST=3, COOLDOWN=2, startOfFrame every 10 clk)
// - Place with pattern_sel=1 -> bomb_armed next clk, blast_num=1; blast rises 1 clk after the 4th startOfFrame; blast_num unchanged throughout.
// - Blast phase -> blast high for exactly 3 frames; blast_done is a single 1-clk pulse; busy drops after 2 further frames.
// - bomb_place during ARMED/BLAST/COOLDOWN with pattern_sel=2 -> ignored; blast_num stays 1 and no extra blast.
// - pattern_sel=5 -> blast_num=0.
// - Same-clk place+startOfFrame -> blast starts after 4 subsequent frames, not 3.
// - Reset asserted mid-BLAST -> all outputs 0 next clk, no blast_done. With CHAIN_DETONATE_EN, detonate_now at frame 1 of ARMED -> blast=1 next clk.

Source files
------------

// File: rtl/blast_pkg.sv
// Shared types and pattern codes for the blast sequencer and the blast bitmap renderer.
package blast_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    BLAST    = 2'd2,
    COOLDOWN = 2'd3
  } blast_state_t;

  localparam logic [2:0] PAT_CROSS = 3'd0;
  localparam logic [2:0] PAT_VERT  = 3'd1;
  localparam logic [2:0] PAT_HORZ  = 3'd2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Frame counter: counts enable pulses, clear has priority, hit flags the pulse that lands on the terminal count.
module frame_tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] terminal,
  output logic         hit
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins over enable.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit = enable && (count_q == terminal);

endmodule

// File: rtl/blast_sequencer.sv
// Bomb lifecycle sequencer (arm, fuse, blast, cooldown) driving the blast renderer.
// Optional CHAIN_DETONATE_EN: detonate_now in ARMED forces an immediate blast.
module blast_sequencer
  import blast_pkg::*;
#(
  parameter int FUSE_FRAMES     = 120,
  parameter int BLAST_FRAMES    = 30,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int NUM_PATTERNS    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       bomb_place,
  input  logic [2:0] pattern_sel,
  input  logic       detonate_now,
  output logic       blast,
  output logic [2:0] blast_num,
  output logic       bomb_armed,
  output logic       busy,
  output logic       blast_done
);

  localparam int CW        = $clog2(max3(FUSE_FRAMES, BLAST_FRAMES, COOLDOWN_FRAMES)) + 1;
  localparam int COOL_LAST = (COOLDOWN_FRAMES > 0) ? (COOLDOWN_FRAMES - 1) : 0;
  localparam logic [CW-1:0] FUSE_TERM  = CW'(FUSE_FRAMES - 1);
  localparam logic [CW-1:0] BLAST_TERM = CW'(BLAST_FRAMES - 1);
  localparam logic [CW-1:0] COOL_TERM  = CW'(COOL_LAST);

  blast_state_t state_q, state_d;
  logic [2:0]   blast_num_q, blast_num_d;
  logic         blast_q, blast_d;
  logic         armed_q, armed_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         clear_s;
  logic         hit_s;
  logic         det_s;
  logic [CW-1:0] term_s;

`ifdef CHAIN_DETONATE_EN
  assign det_s = detonate_now;
`else
  logic unused_det_s;
  assign unused_det_s = detonate_now;
  assign det_s        = 1'b0;
`endif

  frame_tick_counter #(.W(CW)) u_frame_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_s),
    .enable   (startOfFrame),
    .terminal (term_s),
    .hit      (hit_s)
  );

  // Next state, counter control and terminal mux; the counter is cleared on every state change.
  always_comb begin
    state_d     = state_q;
    blast_num_d = blast_num_q;
    clear_s     = 1'b0;
    done_d      = 1'b0;
    term_s      = '0;
    case (state_q)
      IDLE: begin
        clear_s = 1'b1;
        if (bomb_place) begin
          state_d = ARMED;
          if (32'(pattern_sel) < NUM_PATTERNS) begin
            blast_num_d = pattern_sel;
          end else begin
            blast_num_d = PAT_CROSS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        term_s = FUSE_TERM;
        if (det_s || hit_s) begin
          state_d = BLAST;
          clear_s = 1'b1;
        end else begin
          state_d = ARMED;
        end
      end
      BLAST: begin
        term_s = BLAST_TERM;
        if (hit_s) begin
          state_d = COOLDOWN;
          clear_s = 1'b1;
          done_d  = 1'b1;
        end else begin
          state_d = BLAST;
        end
      end
      COOLDOWN: begin
        term_s = COOL_TERM;
        if ((COOLDOWN_FRAMES == 0) || hit_s) begin
          state_d = IDLE;
          clear_s = 1'b1;
        end else begin
          state_d = COOLDOWN;
        end
      end
      default: begin
        state_d = IDLE;
        clear_s = 1'b1;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear one clock after the qualifying input.
  always_comb begin
    blast_d = (state_d == BLAST);
    armed_d = (state_d == ARMED);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      blast_num_q <= 3'd0;
      blast_q     <= 1'b0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      blast_num_q <= blast_num_d;
      blast_q     <= blast_d;
      armed_q     <= armed_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign blast      = blast_q;
  assign blast_num  = blast_num_q;
  assign bomb_armed = armed_q;
  assign busy       = busy_q;
  assign blast_done = done_q;

endmodule

// File: tb/tb_blast_sequencer.sv
// Self-checking bench for blast_sequencer (FUSE=4, BLAST=3, COOLDOWN=2, startOfFrame every 10 clk).
module tb_blast_sequencer;

  localparam int F = 4;
  localparam int B = 3;
  localparam int C = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       bomb_place = 1'b0;
  logic [2:0] pattern_sel = 3'd0;
  logic       detonate_now = 1'b0;
  logic       blast, bomb_armed, busy, blast_done;
  logic [2:0] blast_num;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int blast_hi = 0;
  int done_pulses = 0;

  // Model: a bomb's life is described only by how many frames have passed since it was armed.
  bit         m_active = 1'b0;
  int         m_n = 0;
  logic [2:0] m_num = 3'd0;
  bit         m_done = 1'b0;

  blast_sequencer #(
    .FUSE_FRAMES(F), .BLAST_FRAMES(B), .COOLDOWN_FRAMES(C), .NUM_PATTERNS(3)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .bomb_place(bomb_place),
    .pattern_sel(pattern_sel), .detonate_now(detonate_now), .blast(blast),
    .blast_num(blast_num), .bomb_armed(bomb_armed), .busy(busy), .blast_done(blast_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0;
      m_n      <= 0;
      m_num    <= 3'd0;
      m_done   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (bomb_place) begin
          m_active <= 1'b1;
          m_n      <= 0;
          m_num    <= (pattern_sel < 3'd3) ? pattern_sel : 3'd0;
        end
`ifdef CHAIN_DETONATE_EN
      end else if (detonate_now && m_n < F) begin
        m_n <= F;
`endif
      end else if (startOfFrame) begin
        m_n <= m_n + 1;
        if (m_n + 1 == F + B) m_done <= 1'b1;
        if (m_n + 1 == F + B + C) m_active <= 1'b0;
      end
    end
  end

  // Compare every cycle, shortly after the active edge.
  always @(posedge clk) begin
    #1;
    check("armed", int'(bomb_armed), int'(m_active && m_n < F));
    check("blast", int'(blast), int'(m_active && m_n >= F && m_n < F + B));
    check("busy", int'(busy), int'(m_active));
    check("blast_num", int'(blast_num), int'(m_num));
    check("blast_done", int'(blast_done), int'(m_done));
    if (blast === 1'b1) blast_hi++;
    if (blast_done === 1'b1) done_pulses++;
  end

  task automatic tick(input logic p, input logic [2:0] s, input logic d, input logic r);
    @(negedge clk);
    startOfFrame = ((cyc % 10) == 9);
    bomb_place   = p;
    pattern_sel  = s;
    detonate_now = d;
    reset        = r;
    cyc++;
  endtask

  task automatic idle();
    tick(1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  // Tick until the next tick is the one that drives startOfFrame.
  task automatic to_sof_edge();
    while ((cyc % 10) != 9) idle();
  endtask

  task automatic frames(input int k);
    for (int i = 0; i < k; i++) begin
      to_sof_edge();
      idle();
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset state.
    repeat (3) tick(1'b0, 3'd0, 1'b0, 1'b1);
    after_edge();
    check("rst_blast", int'(blast), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_num", int'(blast_num), 0);
    idle();

    // Normal lifecycle with pattern 1 and ignored placements.
    to_sof_edge(); idle(); idle();
    blast_hi = 0; done_pulses = 0;
    tick(1'b1, 3'd1, 1'b0, 1'b0);
    after_edge();
    check("arm_armed", int'(bomb_armed), 1);
    check("arm_num", int'(blast_num), 1);
    tick(1'b1, 3'd2, 1'b0, 1'b0);
    frames(3);
    to_sof_edge();
    check("pre_fuse_blast", int'(blast), 0);
    idle();
    after_edge();
    check("fuse_blast", int'(blast), 1);
    check("fuse_num", int'(blast_num), 1);
    tick(1'b1, 3'd2, 1'b0, 1'b0);
    frames(3);
    tick(1'b1, 3'd2, 1'b0, 1'b0);
    frames(2);
    repeat (5) idle();
    check("blast_len", blast_hi, 30);
    check("done_count", done_pulses, 1);
    check("end_busy", int'(busy), 0);
    check("end_num", int'(blast_num), 1);

    // Invalid pattern, placed in the same clock as a frame pulse.
    blast_hi = 0;
    to_sof_edge();
    tick(1'b1, 3'd5, 1'b0, 1'b0);
    after_edge();
    check("bad_pat_num", int'(blast_num), 0);
    check("bad_pat_armed", int'(bomb_armed), 1);
    frames(3);
    to_sof_edge();
    check("same_clk_pre", int'(blast), 0);
    idle();
    after_edge();
    check("same_clk_blast", int'(blast), 1);
    frames(5);
    repeat (3) idle();

    // Reset while blasting.
    tick(1'b1, 3'd2, 1'b0, 1'b0);
    frames(4);
    repeat (3) idle();
    check("mid_blast_hi", int'(blast), 1);
    done_pulses = 0;
    tick(1'b0, 3'd0, 1'b0, 1'b1);
    after_edge();
    check("rstmid_blast", int'(blast), 0);
    check("rstmid_done", int'(blast_done), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_num", int'(blast_num), 0);
    frames(4);
    check("rstmid_no_done", done_pulses, 0);

`ifdef CHAIN_DETONATE_EN
    // Chain detonation one frame into the fuse.
    tick(1'b1, 3'd0, 1'b0, 1'b0);
    frames(1);
    tick(1'b0, 3'd0, 1'b1, 1'b0);
    after_edge();
    check("chain_blast", int'(blast), 1);
    frames(B + C);
    repeat (3) idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
